// File: rtl/sdrc_responder.sv
// BRAM-backed stand-in for the user-side command port of the Gowin SDRAM HS controller.
// Reproduces init, ack and burst timing; burst data lives in a byte-enabled inferred RAM.
module sdrc_responder #(
   parameter int DepthBitWidth  = 10,
   parameter int InitCycles     = 16,
   parameter int ActivateCycles = 2,
   parameter int RefreshCycles  = 8,
   parameter int WriteAckCycles = 3,
   parameter int ReadLatency    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        I_sdrc_cmd_en,
   input  logic [2:0]  I_sdrc_cmd,
   input  logic        I_sdrc_precharge_ctrl,
   input  logic        I_sdram_power_down,
   input  logic        I_sdram_selfrefresh,
   input  logic [20:0] I_sdrc_addr,
   input  logic [3:0]  I_sdrc_dqm,
   input  logic [31:0] I_sdrc_data,
   input  logic [7:0]  I_sdrc_data_len,
   output logic [31:0] O_sdrc_data,
   output logic        O_sdrc_init_done,
   output logic        O_sdrc_cmd_ack,
   output logic        O_protocol_error
);

   localparam int Depth = 1 << DepthBitWidth;

   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_RD  = 3'b101;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_REF_WAIT, S_ACT_WAIT, S_WR_DATA, S_WR_ACK, S_RD_WAIT, S_RD_DATA
   } state_t;

   state_t                   state_r;
   logic [15:0]              cnt_r;
   logic [DepthBitWidth-1:0] base_r;
   logic [7:0]               len_r;
   logic [7:0]               word_r;
   logic                     row_open_r;
   logic                     init_done_r;
   logic                     ack_r;
   logic                     err_r;
   logic [31:0]              data_r;

   logic [31:0]              mem_r [0:Depth-1];
   logic [31:0]              ram_q_r;

   logic                     accept_s;
   logic                     busy_cmd_s;
   logic                     wr_en_s;
   logic [DepthBitWidth-1:0] wr_addr_s;
   logic [DepthBitWidth-1:0] rd_addr_s;
   logic                     unused_s;

   assign accept_s   = I_sdrc_cmd_en && init_done_r && (state_r == S_IDLE);
   assign busy_cmd_s = I_sdrc_cmd_en && init_done_r && (state_r != S_IDLE);
   assign unused_s   = ^{I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
                         I_sdrc_addr[20:DepthBitWidth]};

   // RAM port addressing: word 0 of a write is stored on the accept edge itself,
   // and the read port runs one word ahead of the output register.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_addr_s = base_r + DepthBitWidth'(word_r);
      rd_addr_s = base_r;
      if (!rst_n) begin
         wr_en_s = 1'b0;
      end else if (accept_s && (I_sdrc_cmd == CMD_WR)) begin
         wr_en_s   = 1'b1;
         wr_addr_s = I_sdrc_addr[DepthBitWidth-1:0];
      end else if (state_r == S_WR_DATA) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
      if (state_r == S_RD_DATA) begin
         rd_addr_s = base_r + DepthBitWidth'(word_r) + DepthBitWidth'(1'b1);
      end else begin
         rd_addr_s = base_r;
      end
   end

   // Byte-enabled storage with a synchronous read port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int b = 0; b < 4; b++) begin
            if (!I_sdrc_dqm[b]) mem_r[wr_addr_s][8*b +: 8] <= I_sdrc_data[8*b +: 8];
         end
      end
      ram_q_r <= mem_r[rd_addr_s];
   end

   // Command FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= S_INIT;
         cnt_r       <= 16'(InitCycles - 1);
         base_r      <= '0;
         len_r       <= 8'd0;
         word_r      <= 8'd0;
         row_open_r  <= 1'b0;
         init_done_r <= 1'b0;
         ack_r       <= 1'b0;
         err_r       <= 1'b0;
         data_r      <= 32'd0;
      end else begin
         ack_r <= 1'b0;
         if (busy_cmd_s) err_r <= 1'b1;
         case (state_r)
            S_INIT: begin
               if (cnt_r == 16'd0) begin
                  init_done_r <= 1'b1;
                  state_r     <= S_IDLE;
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            S_IDLE: begin
               if (accept_s) begin
                  base_r <= I_sdrc_addr[DepthBitWidth-1:0];
                  len_r  <= I_sdrc_data_len;
                  case (I_sdrc_cmd)
                     CMD_REF: begin
                        state_r    <= S_REF_WAIT;
                        cnt_r      <= 16'(RefreshCycles - 1);
                        row_open_r <= 1'b0;
                     end
                     CMD_ACT: begin
                        state_r    <= S_ACT_WAIT;
                        cnt_r      <= 16'(ActivateCycles - 1);
                        row_open_r <= 1'b1;
                     end
                     CMD_WR: begin
                        if (!row_open_r) err_r <= 1'b1;
                        if (I_sdrc_data_len == 8'd0) begin
                           state_r <= S_WR_ACK;
                           cnt_r   <= 16'(WriteAckCycles - 1);
                        end else begin
                           state_r <= S_WR_DATA;
                           word_r  <= 8'd1;
                        end
                     end
                     CMD_RD: begin
                        if (!row_open_r) err_r <= 1'b1;
                        state_r <= S_RD_WAIT;
                        cnt_r   <= 16'(ReadLatency - 2);
                     end
                     default: state_r <= S_IDLE;
                  endcase
               end
            end
            S_REF_WAIT, S_ACT_WAIT, S_WR_ACK: begin
               if (cnt_r == 16'd0) begin
                  ack_r   <= 1'b1;
                  state_r <= S_IDLE;
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            S_WR_DATA: begin
               if (word_r == len_r) begin
                  state_r <= S_WR_ACK;
                  cnt_r   <= 16'(WriteAckCycles - 1);
               end else begin
                  word_r <= word_r + 8'd1;
               end
            end
            S_RD_WAIT: begin
               // Word 0 is being fetched on this edge when the count expires.
               if (cnt_r == 16'd0) begin
                  state_r <= S_RD_DATA;
                  word_r  <= 8'd0;
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            S_RD_DATA: begin
               data_r <= ram_q_r;
               if (word_r == 8'd0) ack_r <= 1'b1;
               if (word_r == len_r) begin
                  state_r <= S_IDLE;
               end else begin
                  word_r <= word_r + 8'd1;
               end
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

   assign O_sdrc_data      = data_r;
   assign O_sdrc_init_done = init_done_r;
   assign O_sdrc_cmd_ack   = ack_r;
   assign O_protocol_error = err_r;

endmodule

// File: tb/tb_sdrc_responder.sv
// Bench for sdrc_responder: per-edge expectation schedule built from the command timing
// rules, a word-array model of storage, directed scenarios and a randomized command stream.
module tb_sdrc_responder;

   localparam int MAXE = 16384;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_en = 1'b0;
   logic [2:0]  cmd = 3'd0;
   logic [20:0] addr = 21'd0;
   logic [3:0]  dqm = 4'd0;
   logic [31:0] wdata = 32'd0;
   logic [7:0]  dlen = 8'd0;
   logic        pc = 1'b0, pd = 1'b0, sr = 1'b0;
   logic [31:0] rdata;
   logic        init_done, ack, perr;

   sdrc_responder dut (
      .clk(clk), .rst_n(rst_n), .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd),
      .I_sdrc_precharge_ctrl(pc), .I_sdram_power_down(pd), .I_sdram_selfrefresh(sr),
      .I_sdrc_addr(addr), .I_sdrc_dqm(dqm), .I_sdrc_data(wdata), .I_sdrc_data_len(dlen),
      .O_sdrc_data(rdata), .O_sdrc_init_done(init_done), .O_sdrc_cmd_ack(ack),
      .O_protocol_error(perr)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   // Expected events, indexed by posedge number.
   bit          ack_s [MAXE];
   bit          dv [MAXE];
   logic [31:0] dsch [MAXE];
   bit          err_set [MAXE];
   bit          init_rise [MAXE];
   bit          rst_sched [MAXE];
   logic [31:0] mem_m [1024];

   int free_e = MAXE, init_ok_e = MAXE, rel_e = 0, acc_e = 0, last_ack_e = 0, init_seen_e = -1;
   bit row_m = 1'b0;
   logic [31:0] md = 32'd0;
   bit merr = 1'b0, minit = 1'b0;
   int checks = 0, errors = 0;
   int ce;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_free();
      while (edge_n + 1 < free_e) tick();
   endtask

   task automatic do_reset(input int n);
      cmd_en = 1'b0;
      rst_n  = 1'b0;
      for (int i = edge_n + 1; i < MAXE; i++) begin
         ack_s[i] = 1'b0; dv[i] = 1'b0; err_set[i] = 1'b0; init_rise[i] = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         rst_sched[edge_n + 1] = 1'b1;
         tick();
      end
      rst_n     = 1'b1;
      rel_e     = edge_n + 1;
      init_rise[rel_e + 15] = 1'b1;
      init_ok_e = rel_e + 16;
      free_e    = init_ok_e;
      row_m     = 1'b0;
   endtask

   // Present one command; the model decides from its own schedule whether it is accepted.
   task automatic issue(input logic [2:0] c, input logic [20:0] a, input logic [7:0] l,
                        input logic [3:0] m, input logic [31:0] d, input bit rnd, input int abort_k);
      int e;
      int base;
      e      = edge_n + 1;
      base   = int'(a[9:0]);
      cmd_en = 1'b1; cmd = c; addr = a; dlen = l; dqm = m;
      wdata  = rnd ? $urandom() : d;
      if (e >= init_ok_e && e < free_e) err_set[e] = 1'b1;
      if (e >= free_e && c == 3'b100) begin
         acc_e = e;
         if (!row_m) err_set[e] = 1'b1;
         for (int k = 0; k <= int'(l); k++) begin
            if (k == abort_k) begin
               do_reset(2);
               return;
            end
            if (k > 0) wdata = rnd ? $urandom() : d + 32'(k);
            for (int b = 0; b < 4; b++)
               if (!m[b]) mem_m[(base + k) & 1023][8*b +: 8] = wdata[8*b +: 8];
            tick();
            cmd_en = 1'b0;
         end
         ack_s[e + int'(l) + 3] = 1'b1;
         free_e = e + int'(l) + 4;
      end else begin
         if (e >= free_e) begin
            acc_e = e;
            case (c)
               3'b001: begin ack_s[e + 8] = 1'b1; free_e = e + 9; row_m = 1'b0; end
               3'b011: begin ack_s[e + 2] = 1'b1; free_e = e + 3; row_m = 1'b1; end
               3'b101: begin
                  if (!row_m) err_set[e] = 1'b1;
                  for (int k = 0; k <= int'(l); k++) begin
                     dv[e + 3 + k]   = 1'b1;
                     dsch[e + 3 + k] = mem_m[(base + k) & 1023];
                  end
                  ack_s[e + 3] = 1'b1;
                  free_e = e + 4 + int'(l);
               end
               default: free_e = e + 1;
            endcase
         end
         tick();
         cmd_en = 1'b0;
      end
   endtask

   // Per-edge comparison of every output against the schedule.
   always @(negedge clk) begin
      ce = edge_n;
      if (ce >= 1 && ce < MAXE) begin
         if (rst_sched[ce]) begin
            md = 32'd0; merr = 1'b0; minit = 1'b0;
         end else begin
            if (dv[ce]) md = dsch[ce];
            if (err_set[ce]) merr = 1'b1;
            if (init_rise[ce]) minit = 1'b1;
         end
         check("ack", 32'(ack), 32'(ack_s[ce] && !rst_sched[ce]));
         check("init_done", 32'(init_done), 32'(minit));
         check("protocol_error", 32'(perr), 32'(merr));
         check("rdata", rdata, md);
         if (ack) last_ack_e = ce;
         if (init_done && init_seen_e < rel_e) init_seen_e = ce;
      end
   end

   initial begin
      int a0;
      do_reset(3);

      // Init, then refresh on the 20th cycle after release.
      while (edge_n + 1 < rel_e + 19) tick();
      issue(3'b001, 21'h0, 8'd0, 4'h0, 32'h0, 1'b0, 999);
      a0 = acc_e;
      wait_free(); tick();
      check("init_cycles", 32'(init_seen_e - rel_e + 1), 32'd16);
      check("ref_ack_delay", 32'(last_ack_e - a0), 32'd8);

      // Activate, 8-word write, 8-word read.
      issue(3'b011, 21'h40, 8'd0, 4'h0, 32'h0, 1'b0, 999);
      a0 = acc_e;
      wait_free(); tick();
      check("act_ack_delay", 32'(last_ack_e - a0), 32'd2);
      issue(3'b100, 21'h40, 8'd7, 4'h0, 32'h1000, 1'b0, 999);
      a0 = acc_e;
      wait_free(); tick();
      check("wr_ack_delay", 32'(last_ack_e - (a0 + 7)), 32'd3);
      issue(3'b101, 21'h40, 8'd7, 4'h0, 32'h0, 1'b0, 999);
      a0 = acc_e;
      wait_free(); tick();
      check("rd_ack_delay", 32'(last_ack_e - a0), 32'd3);
      check("rd_last_word", rdata, 32'h00001007);

      // Byte masking.
      issue(3'b100, 21'h10, 8'd0, 4'b0000, 32'hAABBCCDD, 1'b0, 999);
      wait_free();
      issue(3'b100, 21'h10, 8'd0, 4'b0101, 32'h11223344, 1'b0, 999);
      wait_free();
      issue(3'b101, 21'h10, 8'd0, 4'h0, 32'h0, 1'b0, 999);
      wait_free(); tick();
      check("dqm_merge", rdata, 32'h11BB33DD);
      check("model_dqm", mem_m[16], 32'h11BB33DD);
      check("no_error_yet", 32'(perr), 32'd0);

      // Command during activate wait, then read without activate after reset.
      issue(3'b011, 21'h0, 8'd0, 4'h0, 32'h0, 1'b0, 999);
      a0 = acc_e;
      issue(3'b101, 21'h40, 8'd0, 4'h0, 32'h0, 1'b0, 999);
      wait_free(); tick();
      check("busy_error", 32'(perr), 32'd1);
      check("act_ack_on_time", 32'(last_ack_e - a0), 32'd2);
      do_reset(2);
      wait_free();
      issue(3'b101, 21'h40, 8'd1, 4'h0, 32'h0, 1'b0, 999);
      wait_free(); tick();
      check("closed_row_error", 32'(perr), 32'd1);
      check("closed_row_data", rdata, 32'h00001001);

      // Wrap at the top of storage and single-word read.
      issue(3'b011, 21'h0, 8'd0, 4'h0, 32'h0, 1'b0, 999);
      wait_free();
      issue(3'b100, 21'h3FE, 8'd3, 4'h0, 32'h5000, 1'b0, 999);
      wait_free();
      issue(3'b101, 21'h001, 8'd0, 4'h0, 32'h0, 1'b0, 999);
      a0 = acc_e;
      wait_free(); tick();
      check("wrap_word3", rdata, 32'h00005003);
      check("single_ack_delay", 32'(last_ack_e - a0), 32'd3);
      check("model_wrap", mem_m[0], 32'h00005002);
      issue(3'b101, 21'h1FFFFE, 8'd3, 4'h0, 32'h0, 1'b0, 999);
      wait_free(); tick();

      // Reset in the middle of a write burst.
      issue(3'b100, 21'h80, 8'd7, 4'h0, 32'h7000, 1'b0, 999);
      wait_free();
      issue(3'b100, 21'h80, 8'd7, 4'h0, 32'h8000, 1'b0, 2);
      wait_free();
      issue(3'b011, 21'h80, 8'd0, 4'h0, 32'h0, 1'b0, 999);
      wait_free();
      issue(3'b101, 21'h80, 8'd7, 4'h0, 32'h0, 1'b0, 999);
      wait_free(); tick();
      check("abort_last_word", rdata, 32'h00007007);
      check("model_abort_new", mem_m[129], 32'h00008001);
      check("model_abort_old", mem_m[130], 32'h00007002);

      // Fill storage so every later read has a known value.
      for (int q = 0; q < 4; q++) begin
         issue(3'b100, 21'(q * 256), 8'd255, 4'h0, 32'h0, 1'b1, 999);
         wait_free();
      end

      // Randomized command stream, including busy-time commands and resets.
      for (int it = 0; it < 300 && edge_n < MAXE - 600; it++) begin
         int r;
         logic [2:0] c;
         logic [7:0] l;
         logic [3:0] m;
         int ab;
         r = $urandom_range(0, 19);
         if ($urandom_range(0, 3) != 0) wait_free();
         repeat ($urandom_range(0, 3)) tick();
         if (r == 0) begin
            do_reset($urandom_range(1, 3));
         end else begin
            if (r <= 2)       c = 3'b001;
            else if (r <= 5)  c = 3'b011;
            else if (r <= 10) c = 3'b100;
            else if (r <= 16) c = 3'b101;
            else begin
               case ($urandom_range(0, 3))
                  0: c = 3'b000;
                  1: c = 3'b010;
                  2: c = 3'b110;
                  default: c = 3'b111;
               endcase
            end
            l  = 8'($urandom_range(0, 15));
            m  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, int'(l)) : 999;
            issue(c, 21'($urandom()), l, m, 32'h0, 1'b1, ab);
         end
      end
      wait_free();
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
